// File: rtl/seg_dyn_scan_if.sv
// Frame-load channel of the seven-segment scan controller: six hex digits,
// their decimal points, a capture strobe and the commit acknowledge.
interface seg_dyn_scan_if;
    logic [23:0] data;
    logic [5:0]  point;
    logic        data_vld;
    logic        load_ack;

    modport master (output data, output point, output data_vld, input load_ack);
    modport slave  (input data, input point, input data_vld, output load_ack);
endinterface

// File: rtl/seg_dyn_scan.sv
// Six-digit seven-segment dynamic scan controller with tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_dyn_scan #(
    parameter int CNT_MAX = 49_999
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          seg_en,
    seg_dyn_scan_if.slave frame_bus,
    output logic          frame_done,
    output logic [5:0]    sel,
    output logic [7:0]    seg
);

    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]    idx_r, idx_nxt_s;
    logic          boundary_s;

    // Frames are {point[5:0], data[23:0]}.
    logic [29:0]   pend_r, pend_nxt_s;
    logic          pend_flag_r, pend_flag_nxt_s;
    logic [29:0]   shadow_r, shadow_nxt_s;
    logic          commit_s;

    logic [5:0]    sel_r, sel_nxt_s;
    logic [7:0]    seg_r, seg_nxt_s;
    logic          load_ack_r;
    logic          frame_done_r;
    logic [5:0]    blank_mask_s;

    // Active-low a..g pattern (bit 6 = g) for one hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] digit_nib(input logic [23:0] d, input logic [2:0] k);
        logic [3:0] nib;
        case (k)
            3'd0:    nib = d[3:0];
            3'd1:    nib = d[7:4];
            3'd2:    nib = d[11:8];
            3'd3:    nib = d[15:12];
            3'd4:    nib = d[19:16];
            3'd5:    nib = d[23:20];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    function automatic logic pick_bit(input logic [5:0] v, input logic [2:0] k);
        logic b;
        case (k)
            3'd0:    b = v[0];
            3'd1:    b = v[1];
            3'd2:    b = v[2];
            3'd3:    b = v[3];
            3'd4:    b = v[4];
            3'd5:    b = v[5];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

`ifdef SEG_LZB_EN
    // Digit k>0 is blanked when it and every higher nibble are zero.
    function automatic logic [5:0] lzb_mask(input logic [23:0] d);
        logic [5:0] m;
        logic       zero_above;
        m          = 6'h00;
        zero_above = 1'b1;
        for (int k = 5; k >= 1; k--) begin
            zero_above = zero_above & (d[4*k +: 4] == 4'h0);
            m[k]       = zero_above;
        end
        return m;
    endfunction
`endif

    // Scan FSM: next state, slot counter, digit index and frame boundary.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        boundary_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                idx_nxt_s = 3'd0;
                if (seg_en) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!seg_en) begin
                    // Disabling mid-frame throws the partial frame away.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                    idx_nxt_s   = 3'd0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s  = '0;
                    boundary_s = (idx_r == 3'd5);
                    if (idx_r == 3'd5) begin
                        idx_nxt_s = 3'd0;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // Capture into pend; commit to shadow while idle or on a frame boundary.
    always_comb begin
        pend_nxt_s      = pend_r;
        pend_flag_nxt_s = pend_flag_r;
        shadow_nxt_s    = shadow_r;
        commit_s        = 1'b0;
        if (frame_bus.data_vld) begin
            pend_nxt_s      = {frame_bus.point, frame_bus.data};
            pend_flag_nxt_s = 1'b1;
        end else begin
            pend_nxt_s      = pend_r;
            pend_flag_nxt_s = pend_flag_r;
        end
        if ((state_r == ST_IDLE) || boundary_s) begin
            if (frame_bus.data_vld) begin
                // A strobe on the commit cycle bypasses pend.
                shadow_nxt_s    = {frame_bus.point, frame_bus.data};
                pend_flag_nxt_s = 1'b0;
                commit_s        = 1'b1;
            end else if (pend_flag_r) begin
                shadow_nxt_s    = pend_r;
                pend_flag_nxt_s = 1'b0;
                commit_s        = 1'b1;
            end else begin
                commit_s = 1'b0;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Digit select and segment pattern for the digit currently indexed.
    always_comb begin
        sel_nxt_s = 6'h00;
        seg_nxt_s = 8'hFF;
`ifdef SEG_LZB_EN
        blank_mask_s = lzb_mask(shadow_r[23:0]);
`else
        blank_mask_s = 6'h00;
`endif
        if ((state_r == ST_SCAN) && seg_en) begin
            sel_nxt_s = 6'h01 << idx_r;
            if (pick_bit(blank_mask_s, idx_r)) begin
                seg_nxt_s = {~pick_bit(shadow_r[29:24], idx_r), 7'h7F};
            end else begin
                seg_nxt_s = {~pick_bit(shadow_r[29:24], idx_r),
                             hex_decode(digit_nib(shadow_r[23:0], idx_r))};
            end
        end else begin
            sel_nxt_s = 6'h00;
            seg_nxt_s = 8'hFF;
        end
    end

    // State, frame storage and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= 3'd0;
            pend_r       <= 30'd0;
            pend_flag_r  <= 1'b0;
            shadow_r     <= 30'd0;
            sel_r        <= 6'h00;
            seg_r        <= 8'hFF;
            load_ack_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            pend_r       <= pend_nxt_s;
            pend_flag_r  <= pend_flag_nxt_s;
            shadow_r     <= shadow_nxt_s;
            sel_r        <= sel_nxt_s;
            seg_r        <= seg_nxt_s;
            load_ack_r   <= commit_s;
            frame_done_r <= boundary_s;
        end
    end

    assign sel                = sel_r;
    assign seg                = seg_r;
    assign frame_done         = frame_done_r;
    assign frame_bus.load_ack = load_ack_r;

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Randomised self-checking bench for seg_dyn_scan against a position-based
// behavioural model, plus directed literal checks of scan order and handshake.
module tb_seg_dyn_scan;

    localparam int CNT_MAX = 9;
    localparam int SLOT    = CNT_MAX + 1;
    localparam int FRAME   = 6 * SLOT;

    logic       clk;
    logic       rst_n;
    logic       seg_en;
    logic       frame_done;
    logic [5:0] sel;
    logic [7:0] seg;

    seg_dyn_scan_if bus ();

    seg_dyn_scan #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .seg_en     (seg_en),
        .frame_bus  (bus),
        .frame_done (frame_done),
        .sel        (sel),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full active-low patterns including an unlit dot.
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [7:0] model_seg(input logic [29:0] f, input int k);
        logic [23:0] d;
        logic [23:0] upper;
        logic [7:0]  pat;
        d     = f[23:0];
        upper = d >> (4 * k);
        pat   = HEX[upper[3:0]];
`ifdef SEG_LZB_EN
        if (k > 0 && upper == 24'd0) pat = 8'hFF;
`endif
        pat[7] = ~f[24 + k];
        return pat;
    endfunction

    // Model: m_pos is the number of enabled cycles since scanning began (-1 = idle).
    int          m_pos;
    logic [29:0] m_shadow;
    logic [29:0] m_pend;
    bit          m_pflag;
    logic [5:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic        exp_ack;
    logic        exp_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos    = -1;
            m_shadow = 30'd0;
            m_pend   = 30'd0;
            m_pflag  = 1'b0;
            exp_sel  = 6'h00;
            exp_seg  = 8'hFF;
            exp_ack  = 1'b0;
            exp_fd   = 1'b0;
        end else begin
            bit scanning;
            bit bnd;
            bit cmt;
            int dig;
            scanning = (m_pos >= 0) && seg_en;
            dig      = scanning ? (m_pos / SLOT) % 6 : 0;
            bnd      = scanning && ((m_pos % FRAME) == FRAME - 1);
            exp_sel  = scanning ? 6'(1 << dig) : 6'h00;
            exp_seg  = scanning ? model_seg(m_shadow, dig) : 8'hFF;
            cmt      = 1'b0;
            if (m_pos < 0 || bnd) begin
                if (bus.data_vld) begin
                    m_shadow = {bus.point, bus.data};
                    m_pflag  = 1'b0;
                    cmt      = 1'b1;
                end else if (m_pflag) begin
                    m_shadow = m_pend;
                    m_pflag  = 1'b0;
                    cmt      = 1'b1;
                end
            end else if (bus.data_vld) begin
                m_pend  = {bus.point, bus.data};
                m_pflag = 1'b1;
            end
            exp_ack = cmt;
            exp_fd  = bnd;
            m_pos   = seg_en ? m_pos + 1 : -1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sel", {26'd0, sel}, {26'd0, exp_sel});
            check("seg", {24'd0, seg}, {24'd0, exp_seg});
            check("load_ack", {31'd0, bus.load_ack}, {31'd0, exp_ack});
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        end
    end

    task automatic strobe(input logic [23:0] d, input logic [5:0] p);
        bus.data     = d;
        bus.point    = p;
        bus.data_vld = 1'b1;
        @(negedge clk);
        bus.data_vld = 1'b0;
    endtask

    task automatic wait_sel(input logic [5:0] v, input string tag);
        int n;
        n = 0;
        while (sel !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sel !== v) begin
            total++;
            bad++;
            $display("FAIL %s: sel=%0h never reached %0h", tag, sel, v);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (bus.load_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.load_ack !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: load_ack never seen", tag);
        end
    endtask

    logic [7:0] basic_seg [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        int n;
        int acks;
        rst_n        = 1'b0;
        seg_en       = 1'b0;
        bus.data     = 24'd0;
        bus.point    = 6'd0;
        bus.data_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_sel", {26'd0, sel}, 32'h00);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_ack", {31'd0, bus.load_ack}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle commit is immediate.
        strobe(24'h123456, 6'd0);
        check("idle_ack", {31'd0, bus.load_ack}, 32'd1);
        seg_en = 1'b1;
        @(negedge clk);
        check("first_scan_blank", {26'd0, sel}, 32'h00);
        @(negedge clk);
        check("first_scan_sel", {26'd0, sel}, 32'h01);

        // Basic scan order and segment decode.
        for (int k = 0; k < 6; k++) begin
            check("basic_sel", {26'd0, sel}, 32'(1 << k));
            check("basic_seg", {24'd0, seg}, {24'd0, basic_seg[k]});
            repeat (SLOT) @(negedge clk);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
        check("fd_period", n, FRAME);

        // Tear-free update: strobe during digit 2, commit only at the boundary.
        wait_sel(6'h04, "tear_wait");
        strobe(24'hABCDEF, 6'd0);
        check("tear_hold", {24'd0, seg}, 32'h99);
        wait_ack("tear_ack");
        check("tear_fd", {31'd0, frame_done}, 32'd1);
        check("tear_last_sel", {26'd0, sel}, 32'h20);
        check("tear_last_seg", {24'd0, seg}, 32'hF9);
        @(negedge clk);
        check("tear_new_sel", {26'd0, sel}, 32'h01);
        check("tear_new_seg", {24'd0, seg}, 32'h8E);

        // Two strobes in one frame: last wins, one acknowledge.
        wait_sel(6'h02, "two_wait");
        strobe(24'h111111, 6'd0);
        repeat (5) @(negedge clk);
        strobe(24'h222222, 6'd0);
        acks = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.load_ack === 1'b1) acks++;
        end
        check("two_acks", acks, 1);
        wait_sel(6'h01, "two_sel");
        check("two_seg", {24'd0, seg}, 32'hA4);

        // Strobe exactly on the boundary cycle.
        n = 0;
        while (!(m_pos >= 0 && (m_pos % FRAME) == FRAME - 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        strobe(24'h654321, 6'd0);
        check("bnd_ack", {31'd0, bus.load_ack}, 32'd1);
        check("bnd_fd", {31'd0, frame_done}, 32'd1);
        @(negedge clk);
        check("bnd_seg", {24'd0, seg}, 32'hF9);

        // Enable toggle during digit 3.
        wait_sel(6'h08, "en_wait");
        seg_en = 1'b0;
        @(negedge clk);
        check("dis_sel", {26'd0, sel}, 32'h00);
        check("dis_seg", {24'd0, seg}, 32'hFF);
        repeat (3) @(negedge clk);
        seg_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reen_sel", {26'd0, sel}, 32'h01);

        // Decimal point on digit 2 only.
        strobe(24'h123456, 6'b000100);
        wait_ack("dot_ack");
        wait_sel(6'h04, "dot_d2");
        check("dot_d2", {24'd0, seg}, 32'h19);
        wait_sel(6'h08, "dot_d3");
        check("dot_d3", {24'd0, seg}, 32'hB0);

        // Leading zeros.
        strobe(24'h000050, 6'd0);
        wait_ack("lzb_ack");
        wait_sel(6'h01, "lzb_d0");
        check("lzb_d0", {24'd0, seg}, 32'hC0);
        wait_sel(6'h02, "lzb_d1");
        check("lzb_d1", {24'd0, seg}, 32'h92);
        wait_sel(6'h04, "lzb_d2");
`ifdef SEG_LZB_EN
        check("lzb_d2", {24'd0, seg}, 32'hFF);
`else
        check("lzb_d2", {24'd0, seg}, 32'hC0);
`endif

        // Randomised traffic with occasional enable toggles.
        for (int i = 0; i < 2500; i++) begin
            bus.data     = 24'($urandom);
            bus.point    = 6'($urandom);
            bus.data_vld = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) seg_en = ~seg_en;
            @(negedge clk);
        end
        bus.data_vld = 1'b0;
        seg_en       = 1'b1;
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-scan drops pending data.
        wait_sel(6'h08, "arst_wait");
        strobe(24'h987654, 6'h3F);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", {26'd0, sel}, 32'h00);
        check("arst_seg", {24'd0, seg}, 32'hFF);
        check("arst_ack", {31'd0, bus.load_ack}, 32'd0);
        check("arst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sel(6'h01, "arst_sel01");
        check("arst_zero", {24'd0, seg}, 32'hC0);
        repeat (2 * FRAME) @(negedge clk);
        check("arst_still_zero", {24'd0, seg}, {24'd0, model_seg(30'd0, 0)});

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
